seq_check_scheduler: RTL and testbench

- Round-robin scheduler that shares one 8-bit sequence checker among NREQ requesters.
- Arbitrates pending requests and issues one word to the checker with a single-cycle sent pulse.
- Waits a fixed checker latency, with a timeout guard, then returns the match verdict to the granted requester.
- Sits between requester blocks and the checker; keeps a saturating count of matches.

---
 rtl/seq_check_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_seq_check_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_check_scheduler.sv
// Round-robin front end sharing one 8-bit sequence checker among NREQ requesters.
// Issues one word per transaction, waits the checker latency (with timeout) and reports the verdict.
module seq_check_scheduler #(
   parameter int NREQ    = 4,
   parameter int CHK_LAT = 9,
   parameter int TIMEOUT = 32,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*8-1:0] req_data,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic              result,
   output logic              timeout_err,
   output logic              busy,
   output logic [CNT_W-1:0]  match_count,
   output logic              chk_sent,
   output logic [7:0]        chk_data,
   input  logic              chk_ready,
   input  logic              chk_match
);

   // state   | meaning
   // S_IDLE  | waiting for any req while the checker reports ready
   // S_ISSUE | one cycle: word and sent pulse presented to the checker
   // S_WAIT  | counting checker latency, accepting ready or timing out
   // S_REPORT| one cycle: done pulse, verdict and error flag updated

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAT_M1 = CW'(CHK_LAT - 1);
   localparam logic [CW-1:0] TO_M1  = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_REPORT} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            arb_hit;
   logic [IW-1:0]   arb_idx;
   logic [IW-1:0]   arb_pos;
   logic            verdict;
   logic            err;
   logic            issue_go;
   logic            report_go;

   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [NREQ-1:0]  done_q, done_d;
   logic             result_q, result_d;
   logic             timeout_err_q, timeout_err_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] match_count_q, match_count_d;
   logic             chk_sent_q, chk_sent_d;
   logic [7:0]       chk_data_q, chk_data_d;

   function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
      return (i == IW'(NREQ - 1)) ? '0 : i + 1'b1;
   endfunction

   // first asserted request searching upward from the pointer, wrapping
   always_comb begin
      arb_hit = 1'b0;
      arb_idx = '0;
      arb_pos = '0;
      for (int k = 0; k < NREQ; k++) begin
         arb_pos = IW'((int'(ptr_q) + k) % NREQ);
         if (!arb_hit && req[arb_pos]) begin
            arb_hit = 1'b1;
            arb_idx = arb_pos;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      verdict = 1'b0;
      err     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (arb_hit && chk_ready) begin
               state_d = S_ISSUE;
               idx_d   = arb_idx;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
            cnt_d   = '0;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // a ready seen at or after the nominal latency wins over the timeout
            if (cnt_q >= LAT_M1 && chk_ready) begin
               state_d = S_REPORT;
               verdict = chk_match;
               ptr_d   = next_ptr(idx_q);
            end else if (cnt_q >= TO_M1) begin
               state_d = S_REPORT;
               err     = 1'b1;
               ptr_d   = next_ptr(idx_q);
            end
         end
         S_REPORT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   assign issue_go  = (state_q == S_IDLE) && (state_d == S_ISSUE);
   assign report_go = (state_q == S_WAIT) && (state_d == S_REPORT);

   // output values for the coming state, registered below
   always_comb begin
      gnt_d         = '0;
      done_d        = '0;
      chk_sent_d    = issue_go;
      chk_data_d    = chk_data_q;
      result_d      = result_q;
      timeout_err_d = timeout_err_q;
      match_count_d = match_count_q;
      busy_d        = (state_d != S_IDLE);
      if (issue_go) begin
         gnt_d[arb_idx] = 1'b1;
         chk_data_d     = req_data[8*int'(arb_idx) +: 8];
      end
      if (report_go) begin
         done_d[idx_q] = 1'b1;
         result_d      = verdict;
         timeout_err_d = err;
         if (verdict && (match_count_q != '1))
            match_count_d = match_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt_q         <= '0;
         done_q        <= '0;
         result_q      <= 1'b0;
         timeout_err_q <= 1'b0;
         busy_q        <= 1'b0;
         match_count_q <= '0;
         chk_sent_q    <= 1'b0;
         chk_data_q    <= '0;
      end else begin
         gnt_q         <= gnt_d;
         done_q        <= done_d;
         result_q      <= result_d;
         timeout_err_q <= timeout_err_d;
         busy_q        <= busy_d;
         match_count_q <= match_count_d;
         chk_sent_q    <= chk_sent_d;
         chk_data_q    <= chk_data_d;
      end
   end

   assign gnt         = gnt_q;
   assign done        = done_q;
   assign result      = result_q;
   assign timeout_err = timeout_err_q;
   assign busy        = busy_q;
   assign match_count = match_count_q;
   assign chk_sent    = chk_sent_q;
   assign chk_data    = chk_data_q;

endmodule

// File: tb/tb_seq_check_scheduler.sv
// Directed bench for seq_check_scheduler: latency, rotation, wrap, timeout, late ready and reset abort.
module tb_seq_check_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  gnt, done;
   logic        result, timeout_err, busy;
   logic [15:0] match_count;
   logic        chk_sent;
   logic [7:0]  chk_data;
   logic        chk_ready, chk_match;

   int checks = 0;
   int failures = 0;

   seq_check_scheduler #(.NREQ(4), .CHK_LAT(9), .TIMEOUT(32), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data),
      .gnt(gnt), .done(done), .result(result), .timeout_err(timeout_err),
      .busy(busy), .match_count(match_count), .chk_sent(chk_sent),
      .chk_data(chk_data), .chk_ready(chk_ready), .chk_match(chk_match)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_sent(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (chk_sent === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done(output bit ok, output int n);
      ok = 1'b0;
      n = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         n++;
         if (done !== 4'b0000) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      checks++; if (gnt !== 4'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
      checks++; if (done !== 4'b0) begin failures++; $display("FAIL reset_done got=%b exp=0000", done); end
      checks++; if (chk_sent !== 1'b0) begin failures++; $display("FAIL reset_sent got=%b exp=0", chk_sent); end
      checks++; if (chk_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", chk_data); end
      checks++; if (result !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL reset_verdict got=%b%b exp=00", result, timeout_err); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (match_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", match_count); end
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_single;
      bit ok;
      bit early;
      req_data = 32'h0000_0057;
      req = 4'b0001;
      chk_ready = 1'b1;
      chk_match = 1'b1;
      wait_sent(ok);
      checks++; if (!ok) begin failures++; $display("FAIL single_sent got=timeout exp=pulse"); end
      checks++; if (chk_data !== 8'h57) begin failures++; $display("FAIL single_data got=%h exp=57", chk_data); end
      checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
      req_data = 32'h0000_00FF;
      tick();
      checks++; if (chk_sent !== 1'b0 || gnt !== 4'b0) begin failures++; $display("FAIL single_pulse got=%b/%b exp=0/0000", chk_sent, gnt); end
      checks++; if (chk_data !== 8'h57) begin failures++; $display("FAIL single_hold got=%h exp=57", chk_data); end
      early = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done !== 4'b0) early = 1'b1;
      end
      checks++; if (early) begin failures++; $display("FAIL single_early got=done exp=none"); end
      tick();
      checks++; if (done !== 4'b0001) begin failures++; $display("FAIL single_done got=%b exp=0001", done); end
      checks++; if (result !== 1'b1 || timeout_err !== 1'b0) begin failures++; $display("FAIL single_verdict got=%b%b exp=10", result, timeout_err); end
      checks++; if (match_count !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", match_count); end
      req = 4'b0000;
      tick();
      checks++; if (done !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%b/%b exp=0000/0", done, busy); end
      checks++; if (result !== 1'b1) begin failures++; $display("FAIL single_result_hold got=%b exp=1", result); end
   endtask

   task automatic test_round_robin;
      bit ok;
      int n;
      logic [3:0] exp_oh;
      logic [7:0] exp_word;
      do_reset();
      req_data = 32'hD3C2_B1A0;
      chk_ready = 1'b1;
      chk_match = 1'b1;
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         exp_oh = 4'b0001 << (t % 4);
         exp_word = 8'hA0 + 8'(17 * (t % 4));
         wait_sent(ok);
         checks++; if (!ok) begin failures++; $display("FAIL rr_sent t=%0d got=timeout exp=pulse", t); end
         checks++; if (gnt !== exp_oh) begin failures++; $display("FAIL rr_gnt t=%0d got=%b exp=%b", t, gnt, exp_oh); end
         checks++; if (chk_data !== exp_word) begin failures++; $display("FAIL rr_data t=%0d got=%h exp=%h", t, chk_data, exp_word); end
         wait_done(ok, n);
         checks++; if (!ok || n != 10) begin failures++; $display("FAIL rr_latency t=%0d got=%0d exp=10", t, n); end
         checks++; if (done !== exp_oh) begin failures++; $display("FAIL rr_done t=%0d got=%b exp=%b", t, done, exp_oh); end
         checks++; if (match_count !== 16'(t + 1)) begin failures++; $display("FAIL rr_count t=%0d got=%0d exp=%0d", t, match_count, t + 1); end
         tick();
         checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_gap t=%0d got=%b exp=0", t, busy); end
      end
      req = 4'b0000;
   endtask

   task automatic test_wrap;
      bit ok;
      int n;
      do_reset();
      req_data = 32'h4433_2211;
      req = 4'b0010;
      wait_sent(ok);
      checks++; if (!ok || gnt !== 4'b0010) begin failures++; $display("FAIL wrap_first got=%b exp=0010", gnt); end
      wait_done(ok, n);
      req = 4'b0011;
      checks++; if (done !== 4'b0010) begin failures++; $display("FAIL wrap_first_done got=%b exp=0010", done); end
      wait_sent(ok);
      checks++; if (!ok || gnt !== 4'b0001) begin failures++; $display("FAIL wrap_gnt0 got=%b exp=0001", gnt); end
      checks++; if (chk_data !== 8'h11) begin failures++; $display("FAIL wrap_data0 got=%h exp=11", chk_data); end
      wait_done(ok, n);
      checks++; if (done !== 4'b0001) begin failures++; $display("FAIL wrap_done0 got=%b exp=0001", done); end
      req = 4'b0010;
      wait_sent(ok);
      checks++; if (!ok || gnt !== 4'b0010) begin failures++; $display("FAIL wrap_gnt1 got=%b exp=0010", gnt); end
      wait_done(ok, n);
      checks++; if (done !== 4'b0010) begin failures++; $display("FAIL wrap_done1 got=%b exp=0010", done); end
      checks++; if (match_count !== 16'd3) begin failures++; $display("FAIL wrap_count got=%0d exp=3", match_count); end
      req = 4'b0000;
   endtask

   task automatic test_timeout;
      bit ok;
      int n;
      bit sent_seen;
      req = 4'b0001;
      chk_ready = 1'b1;
      chk_match = 1'b1;
      wait_sent(ok);
      chk_ready = 1'b0;
      checks++; if (!ok || gnt !== 4'b0001) begin failures++; $display("FAIL to_gnt got=%b exp=0001", gnt); end
      wait_done(ok, n);
      req = 4'b0000;
      checks++; if (!ok || n != 33) begin failures++; $display("FAIL to_latency got=%0d exp=33", n); end
      checks++; if (done !== 4'b0001) begin failures++; $display("FAIL to_done got=%b exp=0001", done); end
      checks++; if (timeout_err !== 1'b1 || result !== 1'b0) begin failures++; $display("FAIL to_verdict got=err%b res%b exp=err1 res0", timeout_err, result); end
      checks++; if (match_count !== 16'd3) begin failures++; $display("FAIL to_count got=%0d exp=3", match_count); end
      req = 4'b0001;
      sent_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (chk_sent !== 1'b0 || busy !== 1'b0) sent_seen = 1'b1;
      end
      checks++; if (sent_seen) begin failures++; $display("FAIL idle_block got=issued exp=held"); end
   endtask

   task automatic test_late_ready;
      bit ok;
      bit early;
      chk_ready = 1'b1;
      wait_sent(ok);
      chk_ready = 1'b0;
      chk_match = 1'b0;
      checks++; if (!ok || gnt !== 4'b0001) begin failures++; $display("FAIL late_gnt got=%b exp=0001", gnt); end
      early = 1'b0;
      for (int i = 0; i < 13; i++) begin
         tick();
         if (done !== 4'b0) early = 1'b1;
      end
      checks++; if (early) begin failures++; $display("FAIL late_early got=done exp=none"); end
      chk_ready = 1'b1;
      tick();
      req = 4'b0000;
      checks++; if (done !== 4'b0001) begin failures++; $display("FAIL late_done got=%b exp=0001", done); end
      checks++; if (timeout_err !== 1'b0 || result !== 1'b0) begin failures++; $display("FAIL late_verdict got=err%b res%b exp=err0 res0", timeout_err, result); end
      checks++; if (match_count !== 16'd3) begin failures++; $display("FAIL late_count got=%0d exp=3", match_count); end
      chk_match = 1'b1;
      tick();
   endtask

   task automatic test_reset_in_wait;
      bit ok;
      int n;
      bit stray;
      req_data = 32'h003C_0000;
      req = 4'b0100;
      wait_sent(ok);
      checks++; if (!ok || gnt !== 4'b0100 || chk_data !== 8'h3C) begin failures++; $display("FAIL rw_issue got=%b/%h exp=0100/3c", gnt, chk_data); end
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || chk_data !== 8'h00) begin failures++; $display("FAIL rw_async got=%b/%h exp=0/00", busy, chk_data); end
      checks++; if (match_count !== 16'd0) begin failures++; $display("FAIL rw_count got=%0d exp=0", match_count); end
      checks++; if (done !== 4'b0 || gnt !== 4'b0 || chk_sent !== 1'b0) begin failures++; $display("FAIL rw_pulses got=%b/%b/%b exp=0", done, gnt, chk_sent); end
      req = 4'b0000;
      tick();
      tick();
      reset = 1'b0;
      stray = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done !== 4'b0 || busy !== 1'b0) stray = 1'b1;
      end
      checks++; if (stray) begin failures++; $display("FAIL rw_no_done got=activity exp=idle"); end
      req_data = 32'h4433_2211;
      req = 4'b1111;
      wait_sent(ok);
      checks++; if (!ok || gnt !== 4'b0001) begin failures++; $display("FAIL rw_ptr got=%b exp=0001", gnt); end
      wait_done(ok, n);
      req = 4'b0000;
      checks++; if (!ok || done !== 4'b0001) begin failures++; $display("FAIL rw_done got=%b exp=0001", done); end
      checks++; if (match_count !== 16'd1) begin failures++; $display("FAIL rw_recount got=%0d exp=1", match_count); end
   endtask

   initial begin
      reset = 1'b0;
      req = 4'b0;
      req_data = 32'h0;
      chk_ready = 1'b1;
      chk_match = 1'b1;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_timeout();
      test_late_ready();
      test_reset_in_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
